// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one memory request/response port between instruction fetch (IF,
//   read-only) and data access (D, read/write). Requests are granted
//   round-robin. A grant stays locked on one side until the memory accepts
//   it. Read responses come back in order. A small tag FIFO records which
//   side issued each outstanding read, so each response goes to the right
//   requester.
//
// Optional feature:
//   ARB_PERF_CNT_EN - when defined, adds three 32-bit performance counters:
//                     perf_if_grant_o, perf_d_grant_o and perf_conflict_o.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   if_req_* / if_addr_i         IF read request channel
//   if_resp_*                    IF read response channel
//   d_req_* / d_addr_i / d_wen_i / d_wdata_i / d_wstrb_i
//                                D request channel (read or write)
//   d_resp_*                     D read response channel
//   m_req_* / m_addr_o / m_wen_o / m_wdata_o / m_wstrb_o
//                                shared memory request channel
//   m_resp_*                     shared memory response channel
//   resp_err_o                   sticky: a response arrived with no read
//                                outstanding
//   perf_*_o                     performance counters (ARB_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_valid_i,
  output logic                if_req_ready_o,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_resp_data_o,
  output logic                if_resp_valid_o,
  input  logic                if_resp_ready_i,
  input  logic                d_req_valid_i,
  output logic                d_req_ready_o,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic                d_wen_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_resp_data_o,
  output logic                d_resp_valid_o,
  input  logic                d_resp_ready_i,
  output logic                m_req_valid_o,
  input  logic                m_req_ready_i,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic                m_wen_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_resp_data_i,
  input  logic                m_resp_valid_i,
  output logic                m_resp_ready_o,
  output logic                resp_err_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_grant_o,
  output logic [31:0]         perf_d_grant_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {
    SideIf = 1'b0,
    SideD  = 1'b1
  } side_e;

  side_e             lastGrant_q, lastGrant_d;
  logic              lock_q, lock_d;
  side_e             lockSide_q, lockSide_d;
  side_e             tags_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              respErr_q, respErr_d;

  logic  fifoNotFull;
  logic  fifoEmpty;
  logic  ifElig;
  logic  dElig;
  logic  selValid;
  side_e selSide;
  side_e headTag;
  logic  accept;
  logic  push;
  logic  pop;

  // Pointers wrap modulo DEPTH, so DEPTH does not have to be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Grant selection. A locked grant wins over everything else, so the memory
  // sees stable request fields until it accepts them. A side that could issue
  // a read is not eligible while the tag FIFO is full. This holds even if a
  // pop happens in the same cycle, so the full check never depends on the
  // response path. When both sides contend, the side that did not win last
  // time is granted.
  always_comb begin
    fifoNotFull = (count_q < CNT_W'(DEPTH));
    ifElig      = if_req_valid_i && fifoNotFull;
    dElig       = d_req_valid_i && (d_wen_i || fifoNotFull);
    selSide     = SideIf;
    selValid    = 1'b0;
    if (lock_q) begin
      selSide  = lockSide_q;
      selValid = (lockSide_q == SideD) ? d_req_valid_i : if_req_valid_i;
    end else if (ifElig && dElig) begin
      selSide  = (lastGrant_q == SideIf) ? SideD : SideIf;
      selValid = 1'b1;
    end else if (dElig) begin
      selSide  = SideD;
      selValid = 1'b1;
    end else if (ifElig) begin
      selSide  = SideIf;
      selValid = 1'b1;
    end
  end

  // Request mux. IF never writes, so its write fields are forced to zero.
  always_comb begin
    m_req_valid_o  = selValid;
    if_req_ready_o = 1'b0;
    d_req_ready_o  = 1'b0;
    m_addr_o       = if_addr_i;
    m_wen_o        = 1'b0;
    m_wdata_o      = '0;
    m_wstrb_o      = '0;
    if (selSide == SideD) begin
      m_addr_o      = d_addr_i;
      m_wen_o       = d_wen_i;
      m_wdata_o     = d_wdata_i;
      m_wstrb_o     = d_wstrb_i;
      d_req_ready_o = selValid && m_req_ready_i;
    end else begin
      if_req_ready_o = selValid && m_req_ready_i;
    end
  end

  assign accept = selValid && m_req_ready_i;
  assign push   = accept && !((selSide == SideD) && d_wen_i);

  // Response routing. The head tag picks the target requester. If the FIFO
  // is empty, a response has nowhere to go. It is drained (ready=1) and
  // flagged through the sticky error bit.
  always_comb begin
    fifoEmpty       = (count_q == '0);
    headTag         = tags_q[rdPtr_q];
    if_resp_valid_o = 1'b0;
    d_resp_valid_o  = 1'b0;
    m_resp_ready_o  = 1'b1;
    if (!fifoEmpty) begin
      if (headTag == SideD) begin
        d_resp_valid_o = m_resp_valid_i;
        m_resp_ready_o = d_resp_ready_i;
      end else begin
        if_resp_valid_o = m_resp_valid_i;
        m_resp_ready_o  = if_resp_ready_i;
      end
    end
  end

  assign if_resp_data_o = m_resp_data_i;
  assign d_resp_data_o  = m_resp_data_i;
  assign pop            = m_resp_valid_i && m_resp_ready_o && !fifoEmpty;
  assign resp_err_o     = respErr_q;

  // Next-state logic for the grant history, the lock and the tag FIFO.
  always_comb begin
    lastGrant_d = lastGrant_q;
    lock_d      = lock_q;
    lockSide_d  = lockSide_q;
    if (accept) begin
      lastGrant_d = selSide;
      lock_d      = 1'b0;
    end else if (selValid) begin
      lock_d     = 1'b1;
      lockSide_d = selSide;
    end else begin
      lock_d = 1'b0;
    end

    wrPtr_d = push ? nextPtr(wrPtr_q) : wrPtr_q;
    rdPtr_d = pop ? nextPtr(rdPtr_q) : rdPtr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    respErr_d = respErr_q || (m_resp_valid_i && fifoEmpty);
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastGrant_q <= SideIf;
      lock_q      <= 1'b0;
      lockSide_q  <= SideIf;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      respErr_q   <= 1'b0;
    end else begin
      lastGrant_q <= lastGrant_d;
      lock_q      <= lock_d;
      lockSide_q  <= lockSide_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      respErr_q   <= respErr_d;
    end
  end

  // Tag storage: one entry per outstanding read, holding the issuing side.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        tags_q[i] <= SideIf;
      end
    end else if (push) begin
      tags_q[wrPtr_q] <= selSide;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perfIf_q;
  logic [31:0] perfD_q;
  logic [31:0] perfConflict_q;

  // Grant counters count accepts per side. The conflict counter counts
  // cycles where both sides were eligible and no lock forced the choice.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perfIf_q       <= '0;
      perfD_q        <= '0;
      perfConflict_q <= '0;
    end else begin
      if (accept && (selSide == SideIf)) begin
        perfIf_q <= perfIf_q + 32'd1;
      end
      if (accept && (selSide == SideD)) begin
        perfD_q <= perfD_q + 32'd1;
      end
      if (!lock_q && ifElig && dElig) begin
        perfConflict_q <= perfConflict_q + 32'd1;
      end
    end
  end

  assign perf_if_grant_o = perfIf_q;
  assign perf_d_grant_o  = perfD_q;
  assign perf_conflict_o = perfConflict_q;
`endif

  // STRB_W is kept for readability of the strobe width relationship.
  logic unusedStrbW;
  assign unusedStrbW = (STRB_W == 0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural reference model is
// built from the arbitration rules: round-robin with lock-until-accept, and
// an in-order queue of outstanding read owners. Every cycle, the model
// predicts the DUT's combinational outputs. Directed scenarios run first,
// then a randomized phase.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_resp_data;
  logic          if_resp_valid, if_resp_ready;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_addr;
  logic          d_wen;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic [DW-1:0] d_resp_data;
  logic          d_resp_valid, d_resp_ready;
  logic          m_req_valid, m_req_ready;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_resp_data;
  logic          m_resp_valid, m_resp_ready;
  logic          resp_err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_if_grant, perf_d_grant, perf_conflict;
`endif

  // Reference model state.
  bit            mLast;
  bit            mLock;
  bit            mLockSide;
  bit            mErr;
  bit            mTags[$];
  logic [DW-1:0] memQ[$];
  bit            ifPend;
  bit            dPend;
  int unsigned   pIf, pD, pConf;

  int unsigned   nChecks = 0;
  int unsigned   nFails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_req_valid_i  (if_req_valid),
    .if_req_ready_o  (if_req_ready),
    .if_addr_i       (if_addr),
    .if_resp_data_o  (if_resp_data),
    .if_resp_valid_o (if_resp_valid),
    .if_resp_ready_i (if_resp_ready),
    .d_req_valid_i   (d_req_valid),
    .d_req_ready_o   (d_req_ready),
    .d_addr_i        (d_addr),
    .d_wen_i         (d_wen),
    .d_wdata_i       (d_wdata),
    .d_wstrb_i       (d_wstrb),
    .d_resp_data_o   (d_resp_data),
    .d_resp_valid_o  (d_resp_valid),
    .d_resp_ready_i  (d_resp_ready),
    .m_req_valid_o   (m_req_valid),
    .m_req_ready_i   (m_req_ready),
    .m_addr_o        (m_addr),
    .m_wen_o         (m_wen),
    .m_wdata_o       (m_wdata),
    .m_wstrb_o       (m_wstrb),
    .m_resp_data_i   (m_resp_data),
    .m_resp_valid_i  (m_resp_valid),
    .m_resp_ready_o  (m_resp_ready),
    .resp_err_o      (resp_err)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_grant_o (perf_if_grant),
    .perf_d_grant_o  (perf_d_grant),
    .perf_conflict_o (perf_conflict)
`endif
  );

  // Single comparison point: counts each check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nChecks++;
    if (obs !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Drives one cycle's worth of inputs (blocking, away from the clock edge).
  task automatic applyStimulus(input bit ifv, input logic [AW-1:0] ifa,
                               input bit dv, input bit dw, input logic [AW-1:0] da,
                               input logic [DW-1:0] dwd, input logic [SW-1:0] ds,
                               input bit mr, input bit rv, input logic [DW-1:0] rd);
    if_req_valid = ifv;
    if_addr      = ifa;
    d_req_valid  = dv;
    d_wen        = dw;
    d_addr       = da;
    d_wdata      = dwd;
    d_wstrb      = ds;
    m_req_ready  = mr;
    m_resp_valid = rv;
    m_resp_data  = rd;
  endtask

  // At the falling edge: predict and check all combinational outputs from
  // the model, then advance the model to its post-edge state. Afterwards,
  // wait until just past the next rising edge.
  task automatic runCycle();
    bit notFull, ifE, dE, selV, sel, acc, isRead, tgtReady;
    @(negedge clk);
    notFull = (mTags.size() < DEPTH);
    ifE  = if_req_valid && notFull;
    dE   = d_req_valid && (d_wen || notFull);
    selV = 1'b0;
    sel  = 1'b0;
    if (mLock) begin
      sel  = mLockSide;
      selV = sel ? d_req_valid : if_req_valid;
    end else if (ifE && dE) begin
      sel  = !mLast;
      selV = 1'b1;
    end else if (dE) begin
      sel  = 1'b1;
      selV = 1'b1;
    end else if (ifE) begin
      selV = 1'b1;
    end

    checkOutput("mReqValid", m_req_valid, selV);
    checkOutput("ifReqReady", if_req_ready, selV && !sel && m_req_ready);
    checkOutput("dReqReady", d_req_ready, selV && sel && m_req_ready);
    if (selV) begin
      checkOutput("mAddr", m_addr, sel ? d_addr : if_addr);
      checkOutput("mWen", m_wen, sel && d_wen);
      checkOutput("mWstrb", m_wstrb, sel ? d_wstrb : '0);
      if (sel && d_wen) checkOutput("mWdata", m_wdata, d_wdata);
    end
    checkOutput("respErr", resp_err, mErr);

    if (mTags.size() == 0) begin
      tgtReady = 1'b1;
      checkOutput("mRespReadyEmpty", m_resp_ready, 1'b1);
      checkOutput("ifRespValidEmpty", if_resp_valid, 1'b0);
      checkOutput("dRespValidEmpty", d_resp_valid, 1'b0);
    end else begin
      tgtReady = mTags[0] ? d_resp_ready : if_resp_ready;
      checkOutput("mRespReady", m_resp_ready, tgtReady);
      checkOutput("ifRespValid", if_resp_valid, m_resp_valid && !mTags[0]);
      checkOutput("dRespValid", d_resp_valid, m_resp_valid && mTags[0]);
      if (m_resp_valid) begin
        if (mTags[0]) checkOutput("dRespData", d_resp_data, m_resp_data);
        else          checkOutput("ifRespData", if_resp_data, m_resp_data);
      end
    end

    acc    = selV && m_req_ready;
    isRead = acc && !(sel && d_wen);
    ifPend = if_req_valid && !(acc && !sel);
    dPend  = d_req_valid && !(acc && sel);
    if (!mLock && ifE && dE) pConf++;
    if (acc) begin
      if (sel) pD++;
      else     pIf++;
    end

    if (rst) begin
      mLast = 1'b0; mLock = 1'b0; mLockSide = 1'b0; mErr = 1'b0;
      mTags.delete();
      memQ.delete();
      ifPend = 1'b0; dPend = 1'b0;
      pIf = 0; pD = 0; pConf = 0;
    end else begin
      if (m_resp_valid && mTags.size() == 0) mErr = 1'b1;
      if (m_resp_valid && tgtReady && mTags.size() > 0) begin
        void'(mTags.pop_front());
        if (memQ.size() > 0) void'(memQ.pop_front());
      end
      if (acc) begin
        mLast = sel;
        mLock = 1'b0;
        if (isRead) begin
          mTags.push_back(sel);
          memQ.push_back(memData(sel ? d_addr : if_addr));
        end
      end else if (selV) begin
        mLock     = 1'b1;
        mLockSide = sel;
      end else begin
        mLock = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_resp_ready = 1'b1;
    d_resp_ready  = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mLast = 0; mLock = 0; mLockSide = 0; mErr = 0;
    pIf = 0; pD = 0; pConf = 0;
    @(posedge clk);
    #1;
    resetDut();
    #1;
    checkOutput("rstMReqValid", m_req_valid, 1'b0);
    checkOutput("rstMRespReady", m_resp_ready, 1'b1);
    checkOutput("rstRespErr", resp_err, 1'b0);

    // IF read with an immediate accept, then its response.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t1IfAccept", if_req_ready, 1'b1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD);
    #1 checkOutput("t1IfData", if_resp_data, 32'hDEAD);
    checkOutput("t1DValid", d_resp_valid, 1'b0);
    runCycle();

    // First contention after reset goes to D; responses return in order.
    resetDut();
    applyStimulus(1, 32'h300, 1, 0, 32'h400, 0, 0, 1, 0, 0);
    #1 checkOutput("t2DFirst", d_req_ready, 1'b1);
    checkOutput("t2AddrD", m_addr, 32'h400);
    runCycle();
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t2IfNext", if_req_ready, 1'b1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA);
    #1 checkOutput("t2RespToD", d_resp_valid, 1'b1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hB);
    #1 checkOutput("t2RespToIf", if_resp_valid, 1'b1);
    runCycle();

    // A stalled D write holds the port while IF waits.
    resetDut();
    applyStimulus(0, 0, 1, 1, 32'h200, 32'h1234_5678, 4'hF, 0, 0, 0);
    #1 checkOutput("t3Hold0", m_addr, 32'h200);
    runCycle();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(1, 32'h500, 1, 1, 32'h200, 32'h1234_5678, 4'hF, 0, 0, 0);
      #1 checkOutput("t3Hold", m_addr, 32'h200);
      runCycle();
    end
    applyStimulus(1, 32'h500, 1, 1, 32'h200, 32'h1234_5678, 4'hF, 1, 0, 0);
    #1 checkOutput("t3DAccept", d_req_ready, 1'b1);
    checkOutput("t3IfWait", if_req_ready, 1'b0);
    runCycle();
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t3IfAfter", if_req_ready, 1'b1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77);
    runCycle();

    // A full tag FIFO blocks reads but lets a write through.
    resetDut();
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0);
    runCycle();
    applyStimulus(1, 32'h604, 0, 0, 0, 0, 0, 1, 0, 0);
    runCycle();
    applyStimulus(1, 32'h608, 1, 1, 32'h700, 32'hCAFE, 4'h3, 1, 0, 0);
    #1 checkOutput("t4IfBlocked", if_req_ready, 1'b0);
    checkOutput("t4DWrite", d_req_ready, 1'b1);
    runCycle();
    applyStimulus(1, 32'h608, 0, 0, 0, 0, 0, 1, 1, 32'h11);
    #1 checkOutput("t4FullWithPop", if_req_ready, 1'b0);
    runCycle();
    applyStimulus(1, 32'h608, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t4IfAccepted", if_req_ready, 1'b1);
    runCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h22);
      runCycle();
    end

    // Unexpected responses set the sticky error; reset clears outstanding reads.
    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    #1 checkOutput("t5DrainReady", m_resp_ready, 1'b1);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("t5ErrSet", resp_err, 1'b1);
    runCycle();
    applyStimulus(1, 32'h800, 0, 0, 0, 0, 0, 1, 0, 0);
    runCycle();
    applyStimulus(1, 32'h804, 0, 0, 0, 0, 0, 1, 0, 0);
    #1 checkOutput("t5ErrSticky", resp_err, 1'b1);
    runCycle();
    resetDut();
    #1 checkOutput("t5ErrCleared", resp_err, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
    #1 checkOutput("t5NoRoute", if_resp_valid, 1'b0);
    checkOutput("t5ReadyAfterRst", m_resp_ready, 1'b1);
    runCycle();
    #1 checkOutput("t5ErrAgain", resp_err, 1'b1);

    // Randomized traffic; requesters hold valid and fields until accepted.
    resetDut();
    for (int c = 0; c < 500; c++) begin
      if (!ifPend) begin
        if_req_valid = 1'($urandom_range(0, 1));
        if_addr      = $urandom & 32'hFFFF_FFFC;
      end
      if (!dPend) begin
        d_req_valid = 1'($urandom_range(0, 1));
        d_wen       = 1'($urandom_range(0, 1));
        d_addr      = $urandom & 32'hFFFF_FFFC;
        d_wdata     = $urandom;
        d_wstrb     = 4'($urandom);
      end
      m_req_ready   = ($urandom_range(0, 3) != 0);
      if_resp_ready = ($urandom_range(0, 3) != 0);
      d_resp_ready  = ($urandom_range(0, 3) != 0);
      if (memQ.size() > 0) begin
        m_resp_valid = ($urandom_range(0, 2) != 0);
        m_resp_data  = memQ[0];
      end else begin
        m_resp_valid = ($urandom_range(0, 49) == 0);
        m_resp_data  = $urandom;
      end
      runCycle();
    end

`ifdef ARB_PERF_CNT_EN
    checkOutput("perfIfGrant", perf_if_grant, pIf);
    checkOutput("perfDGrant", perf_d_grant, pD);
    checkOutput("perfConflict", perf_conflict, pConf);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
